// File: rtl/key_scheduler.sv
// rtl/key_scheduler.sv - AES-256 key expansion and round-key register file
// Expands a 256-bit key one round key per cycle and serves keys by round index.
module key_scheduler (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_load,
  input  logic [255:0] key_in,
  input  logic [3:0]   round_idx,
  input  logic         encryption_flag,
  output logic [127:0] round_key,
  output logic         key_busy,
  output logic         key_valid
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXPAND = 2'd1, DONE = 2'd2} state_t;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    sbox = SBOX[2047 - 8 * int'(x) -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    sub_word = {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  state_t         state_q, state_d;
  logic [3:0]     gen_idx_q, gen_idx_d;
  logic [127:0]   rk_q [15];
  // Sliding 8-word window, oldest word in the top bits.
  logic [255:0]   win_q;
  logic           load_go, step_go;
  logic [31:0]    last_w, sub_in, sub_w, temp_w;
  logic [31:0]    n0, n1, n2, n3;
  logic [7:0]     rcon;
  logic [127:0]   new_rk;
  logic [3:0]     sel;

  always_comb begin
    last_w = win_q[31:0];
    sub_in = gen_idx_q[0] ? last_w : {last_w[23:0], last_w[31:24]};
    sub_w  = sub_word(sub_in);
    rcon   = 8'h01 << (gen_idx_q[3:1] - 3'd1);
    temp_w = gen_idx_q[0] ? sub_w : (sub_w ^ {rcon, 24'h0});
    n0     = win_q[255:224] ^ temp_w;
    n1     = win_q[223:192] ^ n0;
    n2     = win_q[191:160] ^ n1;
    n3     = win_q[159:128] ^ n2;
    new_rk = {n0, n1, n2, n3};
  end

  always_comb begin
    state_d   = state_q;
    gen_idx_d = gen_idx_q;
    load_go   = 1'b0;
    step_go   = 1'b0;
    key_busy  = 1'b0;
    key_valid = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        key_valid = (state_q == DONE);
        if (key_load) begin
          load_go   = 1'b1;
          gen_idx_d = 4'd2;
          state_d   = EXPAND;
        end
      end
      EXPAND: begin
        key_busy  = 1'b1;
        step_go   = 1'b1;
        gen_idx_d = gen_idx_q + 4'd1;
        if (gen_idx_q == 4'd14) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gen_idx_q <= 4'd0;
      win_q     <= '0;
      for (int i = 0; i < 15; i++) rk_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      gen_idx_q <= gen_idx_d;
      if (load_go) begin
        rk_q[0] <= key_in[255:128];
        rk_q[1] <= key_in[127:0];
        win_q   <= key_in;
      end else if (step_go) begin
        rk_q[gen_idx_q] <= new_rk;
        win_q           <= {win_q[127:0], new_rk};
      end
    end
  end

  // Decrypt walks the schedule backwards; index 15 is a reserved zero key.
  always_comb begin
    round_key = '0;
    sel       = encryption_flag ? round_idx : (4'd14 - round_idx);
    if (round_idx != 4'd15) round_key = rk_q[sel];
  end

endmodule

// File: tb/tb_key_scheduler.sv
// tb/tb_key_scheduler.sv - scoreboard bench for key_scheduler
// Reference: FIPS-style word expansion with an S-box derived from GF(2^8) inverses.
module tb_key_scheduler;

  logic         clk = 1'b0;
  logic         rst;
  logic         key_load;
  logic [255:0] key_in;
  logic [3:0]   round_idx;
  logic         encryption_flag;
  logic [127:0] round_key;
  logic         key_busy;
  logic         key_valid;

  key_scheduler dut (
    .clk(clk), .rst(rst), .key_load(key_load), .key_in(key_in),
    .round_idx(round_idx), .encryption_flag(encryption_flag),
    .round_key(round_key), .key_busy(key_busy), .key_valid(key_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   ridx;
    logic         flag;
    logic [127:0] key;
    logic         busy;
    logic         valid;
  } exp_t;

  exp_t sb [$];
  int checks = 0;
  int passes = 0;

  logic [7:0]   sb_tab [256];
  logic [127:0] m_rk [15];
  logic [127:0] m_full [15];
  logic         m_busy, m_valid;
  int           m_next;

  localparam logic [255:0] KEY_A3 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] RK0_A3  = 128'h603deb1015ca71be2b73aef0857d7781;
  localparam logic [127:0] RK2_A3  = 128'h9ba354118e6925afa51a8b5f2067fcde;
  localparam logic [127:0] RK14_A3 = 128'hfe4890d1e6188d0b046df344706c631e;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h0, x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h0;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb_tab[w[31:24]], sb_tab[w[23:16]], sb_tab[w[15:8]], sb_tab[w[7:0]]};
  endfunction

  task automatic expand_key(input logic [255:0] k);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 8; i++) w[i] = k[255 - 32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (i % 8 == 4) begin
        t = subw(t);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int r = 0; r < 15; r++) m_full[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic model_edge(input logic r, input logic ld, input logic [255:0] k);
    if (r) begin
      for (int i = 0; i < 15; i++) m_rk[i] = '0;
      m_busy = 1'b0; m_valid = 1'b0; m_next = 0;
    end else if (ld && !m_busy) begin
      expand_key(k);
      m_rk[0] = m_full[0];
      m_rk[1] = m_full[1];
      m_next = 2; m_busy = 1'b1; m_valid = 1'b0;
    end else if (m_busy) begin
      m_rk[m_next] = m_full[m_next];
      if (m_next == 14) begin
        m_busy = 1'b0; m_valid = 1'b1;
      end
      m_next++;
    end
  endtask

  function automatic logic [127:0] model_key(input logic [3:0] ri, input logic fl);
    if (ri == 4'd15) return '0;
    return fl ? m_rk[ri] : m_rk[14 - int'(ri)];
  endfunction

  task automatic step(input logic r, input logic ld, input logic [255:0] k,
                      input logic [3:0] ri, input logic fl,
                      input logic use_c, input logic [127:0] cval);
    exp_t e;
    rst = r; key_load = ld; key_in = k; round_idx = ri; encryption_flag = fl;
    e.ridx = ri; e.flag = fl; e.busy = m_busy; e.valid = m_valid;
    e.key = use_c ? cval : model_key(ri, fl);
    sb.push_back(e);
    @(posedge clk);
    model_edge(r, ld, k);
    #1;
  endtask

  task automatic idle(input logic [3:0] ri, input logic fl);
    step(1'b0, 1'b0, '0, ri, fl, 1'b0, '0);
  endtask

  task automatic idle_rand();
    idle(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
  endtask

  task automatic sweep_all();
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 16; i++) idle(4'(i), 1'(f));
  endtask

  function automatic logic [255:0] rand_key();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (round_key === e.key) passes++;
      else $display("FAIL round_key idx=%0d enc=%0d got=%h exp=%h", e.ridx, e.flag, round_key, e.key);
      checks++;
      if (key_busy === e.busy) passes++;
      else $display("FAIL key_busy got=%b exp=%b", key_busy, e.busy);
      checks++;
      if (key_valid === e.valid) passes++;
      else $display("FAIL key_valid got=%b exp=%b", key_valid, e.valid);
    end
  end

  initial begin
    build_sbox();
    rst = 1'b1; key_load = 1'b0; key_in = '0; round_idx = '0; encryption_flag = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_edge(1'b1, 1'b0, '0);

    step(1'b1, 1'b0, '0, 4'd3, 1'b1, 1'b0, '0);
    step(1'b1, 1'b1, rand_key(), 4'd9, 1'b0, 1'b0, '0);
    sweep_all();

    step(1'b0, 1'b1, KEY_A3, 4'd0, 1'b1, 1'b0, '0);
    repeat (13) idle_rand();
    step(1'b0, 1'b0, '0, 4'd2,  1'b1, 1'b1, RK2_A3);
    step(1'b0, 1'b0, '0, 4'd14, 1'b1, 1'b1, RK14_A3);
    step(1'b0, 1'b0, '0, 4'd0,  1'b0, 1'b1, RK14_A3);
    step(1'b0, 1'b0, '0, 4'd14, 1'b0, 1'b1, RK0_A3);
    step(1'b0, 1'b0, '0, 4'd15, 1'b0, 1'b1, '0);
    step(1'b0, 1'b0, '0, 4'd15, 1'b1, 1'b1, '0);

    step(1'b0, 1'b1, KEY_A3, 4'd0, 1'b1, 1'b0, '0);
    for (int c = 1; c <= 13; c++)
      step(1'b0, (c == 3 || c == 7), rand_key(), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), 1'b0, '0);
    step(1'b0, 1'b0, '0, 4'd2,  1'b1, 1'b1, RK2_A3);
    step(1'b0, 1'b0, '0, 4'd0,  1'b0, 1'b1, RK14_A3);
    for (int i = 0; i < 15; i++) idle(4'(i), 1'b1);

    step(1'b0, 1'b1, '0, 4'd5, 1'b1, 1'b0, '0);
    repeat (13) idle_rand();
    for (int i = 0; i < 15; i++) idle(4'(i), 1'b1);

    step(1'b0, 1'b1, rand_key(), 4'd1, 1'b1, 1'b0, '0);
    repeat (5) idle_rand();
    step(1'b1, 1'b1, rand_key(), 4'd4, 1'b1, 1'b0, '0);
    sweep_all();

    for (int n = 0; n < 400; n++)
      step($urandom_range(0, 99) == 0, $urandom_range(0, 9) == 0, rand_key(),
           4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b0, '0);
    rst = 1'b0; key_load = 1'b0;

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
